// File: rtl/school_seating_pkg.sv
// Shared types and sizes for the study-room seat register file.
package school_seating_pkg;

  localparam int NUM_SEATS = 32;
  localparam int SEAT_W    = $clog2(NUM_SEATS);
  localparam int TIMER_W   = 11;
  localparam int STUDENT_W = 32;

  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

  typedef enum logic [1:0] {
    FREE    = 2'b00,
    RELEASE = 2'b01,
    AWAY    = 2'b10,
    OCCUPY  = 2'b11
  } seat_state_t;

  typedef struct packed {
    logic [STUDENT_W-1:0] owner;
    seat_state_t          state;
    logic [TIMER_W-1:0]   timer;
  } seat_entry_t;

endpackage

// File: rtl/seat_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 and pulses tick on the terminal count.
module seat_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [15:0] TERM = 16'(TICK_DIV - 1);

  logic [15:0] cnt;

  assign tick = (cnt == TERM);

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/school_seating_system.sv
// 32-seat occupancy register file with kiosk write decode and per-seat timers.
// Optional build macro: SEAT_OWNER_CHECK_EN (owner must match to release/pause).
module school_seating_system
  import school_seating_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [STUDENT_W-1:0] Student_No,
  input  logic [SEAT_W-1:0]    Seat_No,
  input  logic                 write,
  output logic [TIMER_W-1:0]   Time,
  input  logic [1:0]           Seat_State
);

  seat_entry_t [NUM_SEATS-1:0] seats;
  seat_entry_t                 cur, nxt;
  logic                        wr_hit, owner_eq, rel_ok, tick;

  seat_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Decode against the addressed seat; wr_hit is only raised for writes that
  // actually change it, so no-op writes leave the timer counting.
  always_comb begin
    cur      = seats[Seat_No];
    nxt      = cur;
    wr_hit   = 1'b0;
    owner_eq = (cur.owner == Student_No);
`ifdef SEAT_OWNER_CHECK_EN
    rel_ok   = owner_eq;
`else
    rel_ok   = 1'b1;
`endif
    if (write) begin
      case (seat_state_t'(Seat_State))
        OCCUPY: begin
          if (cur.state == FREE) begin
            nxt.owner = Student_No;
            nxt.state = OCCUPY;
            nxt.timer = '0;
            wr_hit    = 1'b1;
          end else if (cur.state == AWAY && owner_eq) begin
            nxt.state = OCCUPY;
            wr_hit    = 1'b1;
          end
        end
        AWAY: begin
          if (cur.state == OCCUPY && rel_ok) begin
            nxt.state = AWAY;
            wr_hit    = 1'b1;
          end
        end
        default: begin
          if (rel_ok) begin
            nxt    = '0;
            wr_hit = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seats <= '0;
    end else begin
      for (int s = 0; s < NUM_SEATS; s++) begin
        if (wr_hit && Seat_No == SEAT_W'(s))
          seats[s] <= nxt;
        else if (tick && seats[s].state == OCCUPY && seats[s].timer != TIMER_MAX)
          seats[s].timer <= seats[s].timer + 1'b1;
      end
    end
  end

  assign Time = seats[Seat_No].timer;

endmodule

// File: tb/tb_school_seating_system.sv
// Directed + randomized bench for school_seating_system against a seat-table model.
module tb_school_seating_system;

  logic        clk = 1'b0;
  logic        reset, write;
  logic [31:0] Student_No;
  logic [4:0]  Seat_No;
  logic [1:0]  Seat_State;
  logic [10:0] Time;

  int checks = 0, failures = 0;

  // model: state codes 0 free, 2 away, 3 occupied
  logic [31:0] m_owner [32];
  int          m_st    [32];
  int          m_tmr   [32];

  school_seating_system dut (
    .clk       (clk),
    .reset     (reset),
    .Student_No(Student_No),
    .Seat_No   (Seat_No),
    .write     (write),
    .Time      (Time),
    .Seat_State(Seat_State)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_edge();
    bit written [32];
    bit ok, match;
    int s;
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_owner[i] = 0; m_st[i] = 0; m_tmr[i] = 0;
      end
      return;
    end
    for (int i = 0; i < 32; i++) written[i] = 0;
    if (write) begin
      s     = int'(Seat_No);
      match = (m_owner[s] == Student_No);
`ifdef SEAT_OWNER_CHECK_EN
      ok = match;
`else
      ok = 1'b1;
`endif
      if (Seat_State == 2'd3) begin
        if (m_st[s] == 0) begin
          m_owner[s] = Student_No; m_st[s] = 3; m_tmr[s] = 0; written[s] = 1;
        end else if (m_st[s] == 2 && match) begin
          m_st[s] = 3; written[s] = 1;
        end
      end else if (Seat_State == 2'd2) begin
        if (m_st[s] == 3 && ok) begin
          m_st[s] = 2; written[s] = 1;
        end
      end else if (ok) begin
        m_owner[s] = 0; m_st[s] = 0; m_tmr[s] = 0; written[s] = 1;
      end
    end
    for (int i = 0; i < 32; i++)
      if (!written[i] && m_st[i] == 3 && m_tmr[i] < 2047) m_tmr[i]++;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_write(input logic [31:0] sid, input int seat, input logic [1:0] st);
    Student_No = sid; Seat_No = 5'(seat); Seat_State = st; write = 1'b1;
    step();
    write = 1'b0;
  endtask

  task automatic chk_seat(input string tag, input int seat);
    Seat_No = 5'(seat);
    #1;
    chk(tag, 32'(Time), 32'(m_tmr[seat]));
  endtask

  logic [31:0] pool [4];

  initial begin
    pool[0] = 32'h1FFFFFF; pool[1] = 32'h1EC10F3; pool[2] = 32'h1E7CFCF; pool[3] = 32'h0000ABCD;

    // reset with write asserted; reset must win
    reset = 1'b1; write = 1'b1; Student_No = 32'h1234; Seat_No = 5'd0; Seat_State = 2'b11;
    repeat (2) step();
    reset = 1'b0; write = 1'b0;
    for (int s = 0; s < 32; s++) begin
      Seat_No = 5'(s);
      step();
      chk("reset_time", 32'(Time), 32'd0);
    end

    // claim seat 1
    do_write(32'h1FFFFFF, 1, 2'b11);
    chk("claim_t0", 32'(Time), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("claim_tk", 32'(Time), 32'(k));
      Seat_No = 5'd2; #1;
      chk("seat2_idle", 32'(Time), 32'd0);
      Seat_No = 5'd1; #1;
    end

    // concurrent seats
    do_write(32'h1EC10F3, 2, 2'b11);
    repeat (6) step();
    do_write(32'h1E7CFCF, 5, 2'b11);
    repeat (8) step();
    Seat_No = 5'd2; #1; chk("conc_seat2", 32'(Time), 32'd15);
    Seat_No = 5'd5; #1; chk("conc_seat5", 32'(Time), 32'd8);
    Seat_No = 5'd1; #1; chk("conc_seat1", 32'(Time), 32'd20);

    // release and reclaim by another student
    do_write(32'h1FFFFFF, 1, 2'b01);
    chk("release", 32'(Time), 32'd0);
    step();
    chk("release_hold", 32'(Time), 32'd0);
    do_write(32'h0000ABCD, 1, 2'b11);
    step();
    chk("reclaim", 32'(Time), 32'd1);

    // away / resume on seat 3
    do_write(32'h00000333, 3, 2'b11);
    repeat (5) step();
    chk("away_pre", 32'(Time), 32'd5);
    do_write(32'h00000333, 3, 2'b10);
    chk("away_set", 32'(Time), 32'd5);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("away_hold", 32'(Time), 32'd5);
    end
    do_write(32'h00000444, 3, 2'b11);
    step();
    chk("away_wrong_id", 32'(Time), 32'd5);
    do_write(32'h00000333, 3, 2'b11);
    chk("resume_edge", 32'(Time), 32'd5);
    step();
    chk("resume_count", 32'(Time), 32'd6);

    // saturation on seat 0
    do_write(32'h00000777, 0, 2'b11);
    repeat (2100) step();
    chk("saturate", 32'(Time), 32'd2047);
    step();
    chk("saturate_hold", 32'(Time), 32'd2047);
    do_write(32'h00000888, 0, 2'b01);
`ifdef SEAT_OWNER_CHECK_EN
    chk("nonowner_release", 32'(Time), 32'd2047);
`else
    chk("nonowner_release", 32'(Time), 32'd0);
`endif
    chk_seat("model_seat0", 0);
    chk_seat("model_seat2", 2);

    // randomized traffic against the model, including rare mid-run resets
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      write      = $urandom_range(0, 1) == 1;
      Seat_No    = 5'($urandom_range(0, 7));
      Seat_State = 2'($urandom_range(0, 3));
      Student_No = pool[$urandom_range(0, 3)];
      step();
      reset = 1'b0; write = 1'b0;
      chk("rand_addr", 32'(Time), 32'(m_tmr[int'(Seat_No)]));
      chk_seat("rand_any", int'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/school_seating_system.md
# school_seating_system

Seat-occupancy register file for a 32-seat study room. Each seat holds the owning student number, a 2-bit seat state and an 11-bit occupancy timer. A single write port lets a kiosk claim, pause or release a seat. The timer of the currently addressed seat is presented on `Time`. The block sits between the kiosk input logic and the room status display.

## Interface
- `TICK_DIV`, default 1: clocks per timer tick; legal range 1..65535.
- `clk`  input  1  system clock; all logic is rising-edge.
- `reset`  input  1  synchronous, active-high reset.
- `Student_No`  input  32  student ID for the write.
- `Seat_No`  input  5  seat address (0..31) used for both write and `Time` readout.
- `write`  input  1  write enable, sampled at the rising edge.
- `Time`  output  11  occupancy timer of seat `Seat_No`.
- `Seat_State`  input  2  requested state: 00 FREE, 01 RELEASE, 10 AWAY, 11 OCCUPY.

## Operation
- Per seat:
  - `owner[31:0]`
  - `state[1:0]`, stored as FREE=00, AWAY=10 or OCCUPIED=11; 01 is never stored.
  - `timer[10:0]`
- Write when `write`=1, decoded on `Seat_State`:
  - 11 on a FREE seat: owner←Student_No, state←OCCUPIED, timer←0.
  - 11 on an AWAY seat with matching owner: state←OCCUPIED; timer keeps its value.
  - 11 on a seat already OCCUPIED by the same owner: no change; timer keeps counting.
  - 10 on an OCCUPIED seat: state←AWAY; timer holds.
  - 01 or 00 on any seat: state←FREE, owner←0, timer←0.
  - Any other combination: ignored.
- Timer: every tick, each OCCUPIED seat increments by 1 and saturates at 2047. AWAY and FREE seats hold.
- Tick generation: a prescaler counts 0..TICK_DIV-1 and asserts the tick on the terminal count. With TICK_DIV=1, every clock is a tick.
- A seat that is written in the same cycle as a tick takes the write result; the increment is dropped for that seat.
- `Time` is a combinational read of `timer[Seat_No]`.
- Reset clears all seats to FREE, owner 0, timer 0, and the prescaler to 0. `Time` therefore reads 0.
- Reset has priority over `write`. Reset asserted mid-occupancy discards all state.

## Timing
- Writes take effect at the rising edge where `write`=1. `Time` shows the new value in the same cycle after that edge.
- Occupying a seat at edge N gives `Time`=0 after N, 1 after N+1, k after N+k (TICK_DIV=1).
- `Time` follows `Seat_No` changes combinationally, with zero latency.
- A write stream with `write` held high rewrites on every edge. Repeated OCCUPY by the same owner does not reset the timer.

## Configuration
- `SEAT_OWNER_CHECK_EN`:
  - Defined: RELEASE (01/00) and AWAY (10) are accepted only when Student_No equals the stored owner. Mismatches are ignored.
  - Undefined: any student can release or pause any seat. The owner match for re-occupying an AWAY seat is still required.

## Structure
- Package `school_seating_pkg` holds:
  - `seat_state_t` enum: FREE, RELEASE, AWAY, OCCUPY.
  - `NUM_SEATS`=32, `TIMER_W`=11, `STUDENT_W`=32.
  - `seat_entry_t` struct: owner, state, timer.
- One sub-module, `seat_tick_gen`, is the TICK_DIV prescaler producing the single-cycle tick.
- The seat array and write decode live in the top module.

## Test plan
- Reset: assert `reset` for 2 clocks with `write`=1. Every Seat_No 0..31 must read `Time`=0 afterwards.
- Claim: write Student 0x1FFFFFF, seat 1, state 11 at edge N. `Time` must be 0, then 1, 2 … 4 on the next 4 edges. Seat 2 must read 0 throughout.
- Concurrent seats: occupy seat 2 (0x1EC10F3) and, 7 clocks later, seat 5 (0x1E7CFCF). After 8 more clocks: seat 2 reads 15, seat 5 reads 8, seat 1 keeps counting.
- Release: write 0x1FFFFFF, seat 1, state 01. `Time` must be 0 on the following cycle. A fresh claim of seat 1 by another student must then succeed.
- Away/resume: occupy seat 3 for 5 ticks, then write 10. `Time` must hold 5 for 10 clocks. Writing 11 with the same ID must resume counting at 6. Writing 11 with a different ID must leave the state AWAY.
- Saturation and owner check: hold seat 0 occupied for 2100 clocks; `Time` must stick at 2047. With `SEAT_OWNER_CHECK_EN` defined, a release by a non-owner must leave the timer at 2047.
